// File: rtl/rx_decimator_ber.sv
// rx_decimator_ber: decimate oversampled BPSK samples, slice, align to PRBS reference, count BER
module rx_decimator_ber #(
    parameter int OV_SAMP  = 4,
    parameter int NB_INPUT = 8,
    parameter int MAX_DLY  = 64,
    parameter int NB_DLY   = 6,
    parameter int WINDOW   = 511,
    parameter int NB_CNT   = 32
) (
    input  logic                       clk,
    input  logic                       i_rst_n,
    input  logic signed [NB_INPUT-1:0] i_is_data,
    input  logic                       i_valid,
    input  logic        [1:0]          i_phase_sel,
    input  logic                       i_ref_bit,
    output logic                       o_symbol,
    output logic                       o_sym_valid,
    output logic                       o_lock,
    output logic        [NB_DLY-1:0]   o_delay,
    output logic        [NB_CNT-1:0]   o_bit_cnt,
    output logic        [NB_CNT-1:0]   o_err_cnt
);

    localparam int NB_WIN = $clog2(WINDOW + 1);

    typedef enum logic {SEARCH, LOCKED} state_t;

    state_t              state_q, state_d;
    logic [1:0]          phase_q, phase_d;
    logic [1:0]          ph_sel_q, ph_sel_d;
    logic [MAX_DLY-2:0]  ref_sr_q, ref_sr_d;
    logic [NB_WIN-1:0]   win_cnt_q, win_cnt_d;
    logic                win_err_q, win_err_d;
    logic [NB_DLY-1:0]   dly_q, dly_d;
    logic [NB_CNT-1:0]   bit_cnt_q, bit_cnt_d;
    logic [NB_CNT-1:0]   err_cnt_q, err_cnt_d;
    logic                sym_q, sym_d;
    logic                sym_vld_q, sym_vld_d;

    logic                strb;
    logic                slice;
    logic [MAX_DLY-1:0]  ref_all;
    logic                mismatch;
    logic                ph_chg;
    logic                win_last;

    assign strb     = i_valid && (phase_q == i_phase_sel);
    assign slice    = i_is_data[NB_INPUT-1];
    // Bit 0 is the current reference, bit k the reference seen k strobes ago
    assign ref_all  = {ref_sr_q, i_ref_bit};
    assign mismatch = slice ^ ref_all[dly_q];
    assign ph_chg   = i_phase_sel != ph_sel_q;
    assign win_last = win_cnt_q == NB_WIN'(WINDOW - 1);

    // Next-state: decimation, reference history, alignment search and BER counters
    always_comb begin
        phase_d   = !i_valid ? phase_q : (phase_q == 2'(OV_SAMP - 1)) ? 2'd0 : phase_q + 2'd1;
        ph_sel_d  = i_phase_sel;
        ref_sr_d  = strb ? {ref_sr_q[MAX_DLY-3:0], i_ref_bit} : ref_sr_q;
        sym_d     = strb ? slice : sym_q;
        sym_vld_d = strb;
        state_d   = state_q;
        dly_d     = dly_q;
        win_cnt_d = win_cnt_q;
        win_err_d = win_err_q;
        bit_cnt_d = bit_cnt_q;
        err_cnt_d = err_cnt_q;
        if (state_q == SEARCH) begin
            if (strb && win_last) begin
                win_cnt_d = '0;
                win_err_d = 1'b0;
                if (!(win_err_q || mismatch)) begin
                    state_d   = LOCKED;
                    bit_cnt_d = '0;
                    err_cnt_d = '0;
                end else begin
                    dly_d = (dly_q == NB_DLY'(MAX_DLY - 1)) ? '0 : dly_q + NB_DLY'(1);
                end
            end else if (strb) begin
                win_cnt_d = win_cnt_q + NB_WIN'(1);
                win_err_d = win_err_q || mismatch;
            end
        end else if (ph_chg) begin
            state_d   = SEARCH;
            dly_d     = '0;
            win_cnt_d = '0;
            win_err_d = 1'b0;
        end else if (strb) begin
            bit_cnt_d = bit_cnt_q + NB_CNT'(!(&bit_cnt_q));
            err_cnt_d = err_cnt_q + NB_CNT'(mismatch && !(&err_cnt_q));
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= SEARCH;
            phase_q   <= '0;
            ph_sel_q  <= '0;
            ref_sr_q  <= '0;
            win_cnt_q <= '0;
            win_err_q <= 1'b0;
            dly_q     <= '0;
            bit_cnt_q <= '0;
            err_cnt_q <= '0;
            sym_q     <= 1'b0;
            sym_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            ph_sel_q  <= ph_sel_d;
            ref_sr_q  <= ref_sr_d;
            win_cnt_q <= win_cnt_d;
            win_err_q <= win_err_d;
            dly_q     <= dly_d;
            bit_cnt_q <= bit_cnt_d;
            err_cnt_q <= err_cnt_d;
            sym_q     <= sym_d;
            sym_vld_q <= sym_vld_d;
        end
    end

    assign o_symbol    = sym_q;
    assign o_sym_valid = sym_vld_q;
    assign o_lock      = state_q == LOCKED;
    assign o_delay     = dly_q;
    assign o_bit_cnt   = bit_cnt_q;
    assign o_err_cnt   = err_cnt_q;

endmodule
